// File: rtl/pc_pkg.sv
// Shared types and default vectors for the program-counter unit.
package pc_pkg;

    typedef enum logic [2:0] {
        SRC_RST,
        SRC_EXC,
        SRC_HOLD,
        SRC_ERET,
        SRC_REDIR,
        SRC_POP,
        SRC_SEQ
    } pc_src_e;

    localparam logic [31:0] DEF_RESET_VEC = 32'h0040_0000;
    localparam logic [31:0] DEF_EXC_VEC   = 32'h8000_0180;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: circular buffer, oldest entry overwritten when full.
module pc_ras #(
    parameter int WIDTH     = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full,
    output logic             underflow
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] r_mem [RAS_DEPTH];
    logic [PW-1:0]    r_ptr;
    logic [CW-1:0]    r_cnt;
    logic             r_uf;
    logic [PW-1:0]    w_ptr_inc;
    logic [PW-1:0]    w_ptr_dec;
    logic             w_empty;
    logic             w_full;

    assign w_ptr_inc = r_ptr + PW'(1);
    assign w_ptr_dec = r_ptr - PW'(1);
    assign w_empty   = (r_cnt == '0);
    assign w_full    = (r_cnt == CW'(RAS_DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
            r_cnt <= '0;
            r_uf  <= 1'b0;
        end else begin
            r_uf <= pop && w_empty;
            if (push && pop) begin
                // Pop consumes the top, push refills the same slot.
                if (w_empty)
                    r_cnt <= CW'(1);
            end else if (push) begin
                r_ptr <= w_ptr_inc;
                if (!w_full)
                    r_cnt <= r_cnt + CW'(1);
            end else if (pop && !w_empty) begin
                r_ptr <= w_ptr_dec;
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            if (pop)
                r_mem[r_ptr] <= push_data;
            else
                r_mem[w_ptr_inc] <= push_data;
        end
    end

    assign top       = r_mem[r_ptr];
    assign empty     = w_empty;
    assign full      = w_full;
    assign underflow = r_uf;

endmodule

// File: rtl/pc_unit.sv
// Program counter with redirect, trap/return and return-address prediction.
module pc_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(DEF_RESET_VEC),
    parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(DEF_EXC_VEC),
    parameter int               STEP      = 4,
    parameter int               RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             exc,
    input  logic             eret,
    input  logic             redirect,
    input  logic [WIDTH-1:0] target,
    input  logic             ras_push,
    input  logic [WIDTH-1:0] push_addr,
    input  logic             ras_pop,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus,
    output logic [WIDTH-1:0] epc,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_underflow
);

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_epc;
    logic [WIDTH-1:0] w_plus;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_top;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    pc_src_e          w_src;

    assign w_plus = r_pc + WIDTH'(STEP);

    always_comb begin
        w_src = SRC_SEQ;
        if (rst)
            w_src = SRC_RST;
        else if (exc)
            w_src = SRC_EXC;
        else if (!ena)
            w_src = SRC_HOLD;
        else if (eret)
            w_src = SRC_ERET;
        else if (redirect)
            w_src = SRC_REDIR;
        else if (ras_pop)
            w_src = SRC_POP;
    end

    always_comb begin
        w_next = w_plus;
        case (w_src)
            SRC_RST:   w_next = RESET_VEC;
            SRC_EXC:   w_next = EXC_VEC;
            SRC_HOLD:  w_next = r_pc;
            SRC_ERET:  w_next = r_epc;
            SRC_REDIR: w_next = target;
            // An empty-stack pop falls through to the sequential step.
            SRC_POP:   w_next = w_empty ? w_plus : w_top;
            default:   w_next = w_plus;
        endcase
    end

    assign w_pop  = (w_src == SRC_POP);
    assign w_push = ena && !exc && !rst && ras_push;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc  <= RESET_VEC;
            r_epc <= '0;
        end else begin
            r_pc <= w_next;
            if (w_src == SRC_EXC)
                r_epc <= r_pc;
        end
    end

    pc_ras #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (push_addr),
        .pop       (w_pop),
        .top       (w_top),
        .empty     (w_empty),
        .full      (ras_full),
        .underflow (ras_underflow)
    );

    assign pc        = r_pc;
    assign pc_plus   = w_plus;
    assign epc       = r_epc;
    assign ras_empty = w_empty;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: queue-based stack model, directed then random.
module tb_pc_unit;

    localparam int DEPTH = 4;
    localparam logic [31:0] RV = 32'h0040_0000;
    localparam logic [31:0] EV = 32'h8000_0180;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] plus;
        logic [31:0] epc;
        logic        emp;
        logic        ful;
        logic        uf;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst, ena, exc, eret, redirect, ras_push, ras_pop;
    logic [31:0] target, push_addr;
    logic [31:0] pc, pc_plus, epc;
    logic        ras_empty, ras_full, ras_underflow;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    obs_t        exp_q[$];
    logic [31:0] m_stk[$];
    logic [31:0] m_pc = RV;
    logic [31:0] m_epc = '0;
    logic        m_uf = 1'b0;

    pc_unit dut (
        .clk           (clk),
        .rst           (rst),
        .ena           (ena),
        .exc           (exc),
        .eret          (eret),
        .redirect      (redirect),
        .target        (target),
        .ras_push      (ras_push),
        .push_addr     (push_addr),
        .ras_pop       (ras_pop),
        .pc            (pc),
        .pc_plus       (pc_plus),
        .epc           (epc),
        .ras_empty     (ras_empty),
        .ras_full      (ras_full),
        .ras_underflow (ras_underflow)
    );

    always #5 clk = ~clk;

    task automatic step(input logic r, input logic e, input logic x,
                        input logic er, input logic rd,
                        input logic [31:0] t, input logic pu,
                        input logic [31:0] pa, input logic po);
        logic        take_pop;
        logic [31:0] v;
        obs_t        o;
        rst = r; ena = e; exc = x; eret = er; redirect = rd;
        target = t; ras_push = pu; push_addr = pa; ras_pop = po;
        if (r) begin
            m_pc = RV; m_epc = '0; m_uf = 1'b0;
            m_stk.delete();
        end else if (x) begin
            m_epc = m_pc; m_pc = EV; m_uf = 1'b0;
        end else if (!e) begin
            m_uf = 1'b0;
        end else begin
            take_pop = po && !er && !rd;
            m_uf = take_pop && (m_stk.size() == 0);
            if (er)
                m_pc = m_epc;
            else if (rd)
                m_pc = t;
            else if (take_pop && m_stk.size() > 0) begin
                v = m_stk.pop_back();
                m_pc = v;
            end else
                m_pc = m_pc + 32'd4;
            if (pu) begin
                m_stk.push_back(pa);
                if (m_stk.size() > DEPTH)
                    void'(m_stk.pop_front());
            end
        end
        o.pc = m_pc;
        o.plus = m_pc + 32'd4;
        o.epc = m_epc;
        o.emp = (m_stk.size() == 0);
        o.ful = (m_stk.size() == DEPTH);
        o.uf = m_uf;
        exp_q.push_back(o);
        @(posedge clk);
        #2;
    endtask

    task automatic seq(input int n);
        for (int i = 0; i < n; i++)
            step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic push(input logic [31:0] a);
        step(0, 1, 0, 0, 0, 0, 1, a, 0);
    endtask

    task automatic pop();
        step(0, 1, 0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin : monitor
        obs_t a, w;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                w = exp_q.pop_front();
                a = '{pc, pc_plus, epc, ras_empty, ras_full, ras_underflow};
                n_chk++;
                if (a === w)
                    n_pass++;
                else
                    $display("FAIL cyc%0d state: got pc=%h plus=%h epc=%h e=%b f=%b u=%b want pc=%h plus=%h epc=%h e=%b f=%b u=%b",
                             cyc, a.pc, a.plus, a.epc, a.emp, a.ful, a.uf,
                             w.pc, w.plus, w.epc, w.emp, w.ful, w.uf);
            end
        end
    end

    initial begin : driver
        rst = 1; ena = 0; exc = 0; eret = 0; redirect = 0;
        target = 0; ras_push = 0; push_addr = 0; ras_pop = 0;
        @(posedge clk);
        #2;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        seq(4);
        step(0, 1, 0, 0, 1, 32'h0040_0100, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 1, 32'h0040_0020, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 1, 0, 0, 0, 0, 0);
        push(32'hA0); push(32'hB0); push(32'hC0);
        pop(); pop(); pop(); pop();
        seq(1);
        for (int i = 1; i <= 5; i++)
            push(i);
        for (int i = 0; i < 5; i++)
            pop();
        seq(1);
        push(32'h0000_1234);
        step(0, 1, 0, 0, 1, 32'h0000_0300, 0, 0, 1);
        step(0, 1, 0, 0, 0, 0, 1, 32'h0000_5678, 1);
        pop();
        step(0, 1, 0, 0, 0, 0, 1, 32'h0000_9999, 1);
        step(0, 1, 1, 0, 0, 0, 1, 32'h0000_7777, 1);
        step(1, 1, 1, 0, 0, 0, 1, 32'h0000_7777, 1);
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(63) == 0),
                 ($urandom_range(3) != 0),
                 ($urandom_range(15) == 0),
                 ($urandom_range(9) == 0),
                 ($urandom_range(5) == 0),
                 $urandom(),
                 ($urandom_range(2) == 0),
                 $urandom(),
                 ($urandom_range(2) == 0));
        end
        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            n_chk++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
